// File: rtl/channel_dma_if.sv
// Byte-stream (to/from channel) and byte-IO (to/from memory) bundle for channel_dma.
interface channel_dma_if;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        io_start;
   logic        io_write;
   logic [31:0] io_addr;
   logic [7:0]  io_data_write;
   logic        io_busy;
   logic        io_done;
   logic [7:0]  io_data_read;

   modport master (
      output out_data, out_valid, in_ready, io_start, io_write, io_addr, io_data_write,
      input  out_ready, in_data, in_valid, io_busy, io_done, io_data_read
   );

   modport slave (
      input  out_data, out_valid, in_ready, io_start, io_write, io_addr, io_data_write,
      output out_ready, in_data, in_valid, io_busy, io_done, io_data_read
   );
endinterface

// File: rtl/channel_dma.sv
// Single-channel byte DMA: moves count bytes between a channel byte stream and a byte-IO
// memory port, one byte in flight at a time, with early stop from the channel.
module channel_dma (
   input  logic          clk,
   input  logic          reset,
   input  logic          start_strobe,
   input  logic          write,
   input  logic [31:0]   addr,
   input  logic [15:0]   count,
   input  logic          stop,
   output logic          busy,
   output logic          done_strobe,
   output logic [15:0]   res_count,
   channel_dma_if.master bus
);

   localparam logic [2:0] StIdle      = 3'd0;
   localparam logic [2:0] StFetch     = 3'd1;
   localparam logic [2:0] StFetchWait = 3'd2;
   localparam logic [2:0] StOffer     = 3'd3;
   localparam logic [2:0] StAccept    = 3'd4;
   localparam logic [2:0] StStore     = 3'd5;
   localparam logic [2:0] StStoreWait = 3'd6;
   localparam logic [2:0] StFinish    = 3'd7;

   logic [2:0]  state_q, state_d;
   logic [31:0] addr_q, addr_d, addr_inc;
   logic [15:0] remaining_q, remaining_d, remaining_dec;
   logic [7:0]  buffer_q, buffer_d;
   logic        stop_pending_q, stop_pending_d;

   assign addr_inc      = addr_q + 32'd1;
   assign remaining_dec = (remaining_q == 16'd0) ? 16'd0 : remaining_q - 16'd1;

   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      remaining_d    = remaining_q;
      buffer_d       = buffer_q;
      stop_pending_d = stop_pending_q;
      case (state_q)
         StIdle: begin
            if (start_strobe) begin
               addr_d         = addr;
               remaining_d    = count;
               stop_pending_d = 1'b0;
               if (count == 16'd0) begin
                  state_d = StFinish;
               end else if (write) begin
                  state_d = StAccept;
               end else begin
                  state_d = StFetch;
               end
            end
         end
         StFetch: begin
            if (!bus.io_busy) state_d = StFetchWait;
         end
         StFetchWait: begin
            if (bus.io_done) begin
               buffer_d = bus.io_data_read;
               state_d  = StOffer;
            end
         end
         StOffer: begin
            // A handshake in the stop cycle still counts the byte.
            if (bus.out_ready) begin
               addr_d      = addr_inc;
               remaining_d = remaining_dec;
               state_d     = (remaining_dec == 16'd0 || stop) ? StFinish : StFetch;
            end else if (stop) begin
               state_d = StFinish;
            end
         end
         StAccept: begin
            // The byte only counts once stored, so a coincident stop is deferred.
            if (bus.in_valid) begin
               buffer_d       = bus.in_data;
               stop_pending_d = stop;
               state_d        = StStore;
            end else if (stop) begin
               state_d = StFinish;
            end
         end
         StStore: begin
            if (!bus.io_busy) state_d = StStoreWait;
         end
         StStoreWait: begin
            if (bus.io_done) begin
               addr_d      = addr_inc;
               remaining_d = remaining_dec;
               state_d     = (remaining_dec == 16'd0 || stop_pending_q) ? StFinish : StAccept;
            end
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= StIdle;
         addr_q         <= 32'd0;
         remaining_q    <= 16'd0;
         buffer_q       <= 8'd0;
         stop_pending_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         remaining_q    <= remaining_d;
         buffer_q       <= buffer_d;
         stop_pending_q <= stop_pending_d;
      end
   end

   // remaining is frozen from FINISH until the next accepted start, so it doubles as res_count.
   assign busy              = (state_q != StIdle);
   assign done_strobe       = (state_q == StFinish);
   assign res_count         = remaining_q;
   assign bus.out_valid     = (state_q == StOffer);
   assign bus.out_data      = buffer_q;
   assign bus.in_ready      = (state_q == StAccept);
   assign bus.io_start      = ((state_q == StFetch) || (state_q == StStore)) && !bus.io_busy;
   assign bus.io_write      = (state_q == StStore);
   assign bus.io_addr       = addr_q;
   assign bus.io_data_write = buffer_q;

endmodule

// File: tb/tb_channel_dma.sv
// Bench for channel_dma: directed and random transfers against a channel source/sink and a
// byte memory model, with expected results derived from byte counts and stop rules.
module tb_channel_dma;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start_strobe, write, stop, busy, done_strobe;
   logic [31:0] addr;
   logic [15:0] count, res_count;

   channel_dma_if bus ();

   channel_dma dut (
      .clk          (clk),
      .reset        (reset),
      .start_strobe (start_strobe),
      .write        (write),
      .addr         (addr),
      .count        (count),
      .stop         (stop),
      .busy         (busy),
      .done_strobe  (done_strobe),
      .res_count    (res_count),
      .bus          (bus)
   );

   int compared = 0;
   int mismatched = 0;

   // Requests for the next cycle's inputs
   bit          rst_req = 1'b1;
   bit          st_req = 1'b0;
   logic        st_wr = 1'b0;
   logic [31:0] st_a = 32'd0;
   logic [15:0] st_n = 16'd0;

   // Memory and channel behaviour
   int          mem_lat = -1;
   int          lat_min = 0;
   int          lat_max = 2;
   bit          mem_wr = 1'b0;
   logic [31:0] mem_a = 32'd0;
   int          force_busy = 0;
   int          ready_hold = 0;
   int          stop_mode = 0;
   int          stop_n = 0;
   bit          inj_done = 1'b0;
   logic [7:0]  sent_q[$];
   logic [7:0]  src_q[$];

   // Observations
   logic [7:0]  out_q[$];
   logic [31:0] rd_a_q[$];
   logic [31:0] wr_a_q[$];
   logic [7:0]  wr_d_q[$];
   int          taken = 0, viol = 0, done_cnt = 0, io_start_cnt = 0;
   int          ov_cnt = 0, ir_cnt = 0, cyc = 0, first_io_cyc = -1, start_cyc = 0;
   logic [15:0] res_last = 16'd0;
   bit          pv_pending = 1'b0;
   logic [7:0]  pv_data = 8'd0;

   function automatic logic [7:0] rd_byte(input logic [31:0] a);
      return a[7:0] + 8'hA1;
   endfunction

   // Bytes actually moved: all of them, or as many as were handshaken before stop took effect.
   function automatic int expect_k(input int mode, input int sn, input int n);
      if (mode == 0) return n;
      return (sn < n) ? sn : n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      reset        = rst_req;
      start_strobe = st_req;
      write        = st_wr;
      addr         = st_a;
      count        = st_n;
      st_req       = 1'b0;
      if (rst_req) mem_lat = -1;
      bus.io_done = 1'b0;
      if (inj_done) begin
         bus.io_done      = 1'b1;
         bus.io_data_read = 8'hEE;
         inj_done         = 1'b0;
      end else if (mem_lat == 0) begin
         bus.io_done      = 1'b1;
         bus.io_data_read = mem_wr ? 8'h00 : rd_byte(mem_a);
         mem_lat          = -1;
      end else if (mem_lat > 0) begin
         mem_lat--;
      end
      bus.io_busy = (mem_lat >= 0) || (force_busy > 0);
      if (force_busy > 0) force_busy--;
      stop = 1'b0;
      bus.out_ready = (ready_hold > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (ready_hold > 0) ready_hold--;
      bus.in_valid = (src_q.size() > 0) && ($urandom_range(0, 3) != 0);
      bus.in_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
      if (stop_mode == 1 && taken >= stop_n) begin
         stop          = 1'b1;
         bus.out_ready = 1'b0;
         bus.in_valid  = 1'b0;
      end
      if (stop_mode == 2 && taken >= stop_n - 1) begin
         stop          = 1'b1;
         bus.out_ready = 1'b1;
         bus.in_valid  = (src_q.size() > 0);
      end
      #1;
      if (bus.io_start === 1'b1 && !reset) begin
         io_start_cnt++;
         if (first_io_cyc < 0) first_io_cyc = cyc;
         if (bus.io_busy || mem_lat >= 0) viol++;
         mem_lat = $urandom_range(lat_min, lat_max);
         mem_wr  = bus.io_write;
         mem_a   = bus.io_addr;
         if (bus.io_write) begin
            wr_a_q.push_back(bus.io_addr);
            wr_d_q.push_back(bus.io_data_write);
         end else begin
            rd_a_q.push_back(bus.io_addr);
         end
      end
      if (bus.out_valid === 1'b1) ov_cnt++;
      if (bus.in_ready === 1'b1) ir_cnt++;
      if (bus.out_valid === 1'b1 && bus.in_ready === 1'b1) viol++;
      if (busy === 1'b0 && (bus.out_valid === 1'b1 || bus.in_ready === 1'b1 ||
                            bus.io_start === 1'b1)) viol++;
      if (pv_pending && bus.out_valid === 1'b1 && bus.out_data !== pv_data) viol++;
      pv_pending = (bus.out_valid === 1'b1) && !bus.out_ready;
      pv_data    = bus.out_data;
      if (bus.out_valid === 1'b1 && bus.out_ready && !reset) begin
         out_q.push_back(bus.out_data);
         taken++;
      end
      if (bus.in_valid && bus.in_ready === 1'b1 && !reset) begin
         taken++;
         void'(src_q.pop_front());
      end
      if (done_strobe === 1'b1) begin
         done_cnt++;
         res_last = res_count;
      end
      cyc++;
   endtask

   task automatic clear_obs();
      out_q.delete();
      rd_a_q.delete();
      wr_a_q.delete();
      wr_d_q.delete();
      taken = 0; viol = 0; done_cnt = 0; io_start_cnt = 0;
      ov_cnt = 0; ir_cnt = 0; first_io_cyc = -1; pv_pending = 1'b0;
   endtask

   task automatic fill_src(input int n);
      sent_q.delete();
      repeat (n) sent_q.push_back(8'($urandom));
   endtask

   task automatic start_xfer(input logic wr, input logic [31:0] a, input logic [15:0] n,
                             input int mode, input int sn);
      clear_obs();
      stop_mode = mode;
      stop_n    = sn;
      src_q.delete();
      if (wr) src_q = sent_q;
      start_cyc = cyc;
      st_req = 1'b1; st_wr = wr; st_a = a; st_n = n;
      tick();
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (done_cnt == 0 && k < budget) begin
         tick();
         k++;
      end
      chk("done_seen", 32'(done_cnt != 0), 32'd1);
      stop_mode = 0;
      src_q.delete();
      repeat (2) tick();
   endtask

   task automatic check_xfer(input string tag, input logic wr, input logic [31:0] a,
                             input int n, input int k);
      chk({tag, " done_once"}, 32'(done_cnt), 32'd1);
      chk({tag, " res_count"}, 32'(res_last), 32'(n - k));
      chk({tag, " busy_after"}, 32'(busy), 32'd0);
      chk({tag, " rule_violations"}, 32'(viol), 32'd0);
      if (!wr) begin
         chk({tag, " bytes_out"}, 32'(out_q.size()), 32'(k));
         chk({tag, " no_mem_writes"}, 32'(wr_a_q.size()), 32'd0);
         for (int i = 0; i < k && i < out_q.size() && i < rd_a_q.size(); i++) begin
            chk({tag, " out_data"}, 32'(out_q[i]), 32'(rd_byte(a + 32'(i))));
            chk({tag, " rd_addr"}, rd_a_q[i], a + 32'(i));
         end
      end else begin
         chk({tag, " mem_writes"}, 32'(wr_a_q.size()), 32'(k));
         for (int i = 0; i < k && i < wr_a_q.size(); i++) begin
            chk({tag, " wr_addr"}, wr_a_q[i], a + 32'(i));
            chk({tag, " wr_data"}, 32'(wr_d_q[i]), 32'(sent_q[i]));
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: observed simulation still running, expected finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic        wr;
      logic [31:0] a;
      int          n, mode, sn, k;

      reset = 1'b1; start_strobe = 1'b0; write = 1'b0; stop = 1'b0;
      addr = 32'd0; count = 16'd0;
      bus.out_ready = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'd0;
      bus.io_busy = 1'b0; bus.io_done = 1'b0; bus.io_data_read = 8'd0;

      // Reset state
      rst_req = 1'b1;
      tick();
      tick();
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done_strobe", 32'(done_strobe), 32'd0);
      chk("rst res_count", 32'(res_count), 32'd0);
      chk("rst out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst io_start", 32'(bus.io_start), 32'd0);
      chk("rst io_write", 32'(bus.io_write), 32'd0);
      chk("rst io_addr", bus.io_addr, 32'd0);
      chk("rst io_data_write", 32'(bus.io_data_write), 32'd0);
      chk("rst out_data", 32'(bus.out_data), 32'd0);
      rst_req = 1'b0;
      tick();

      // Memory->device, three bytes
      start_xfer(1'b0, 32'h0000_1000, 16'd3, 0, 0);
      wait_done(200);
      check_xfer("m2d", 1'b0, 32'h0000_1000, 3, 3);

      // Device->memory across the address wrap
      sent_q.delete();
      sent_q.push_back(8'h55);
      sent_q.push_back(8'h66);
      start_xfer(1'b1, 32'hFFFF_FFFF, 16'd2, 0, 0);
      wait_done(200);
      check_xfer("d2m_wrap", 1'b1, 32'hFFFF_FFFF, 2, 2);

      // Zero count
      start_xfer(1'b0, 32'h0000_0100, 16'd0, 0, 0);
      wait_done(2);
      check_xfer("zero", 1'b0, 32'h0000_0100, 0, 0);
      chk("zero io_start", 32'(io_start_cnt), 32'd0);
      chk("zero valid_ready", 32'(ov_cnt + ir_cnt), 32'd0);

      // Early stop after two accepted bytes, then stop alongside the third
      fill_src(5);
      start_xfer(1'b1, 32'h0000_8000, 16'd5, 1, 2);
      wait_done(400);
      check_xfer("stop_after2", 1'b1, 32'h0000_8000, 5, 2);
      fill_src(5);
      start_xfer(1'b1, 32'h0000_9000, 16'd5, 2, 3);
      wait_done(400);
      check_xfer("stop_with3", 1'b1, 32'h0000_9000, 5, 3);

      // Back-pressure on both the memory port and the channel
      force_busy = 5;
      ready_hold = 16;
      start_xfer(1'b0, 32'h0000_2200, 16'd3, 0, 0);
      wait_done(400);
      check_xfer("backpressure", 1'b0, 32'h0000_2200, 3, 3);
      chk("bp io_start_delay", 32'(first_io_cyc - start_cyc >= 5), 32'd1);
      chk("bp io_start_pulses", 32'(io_start_cnt), 32'd3);

      // Random transfers
      for (int it = 0; it < 10; it++) begin
         wr   = 1'($urandom_range(0, 1));
         a    = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3))
                                            : $urandom;
         n    = $urandom_range(1, 6);
         mode = $urandom_range(0, 2);
         sn   = (mode == 2) ? $urandom_range(1, n) : $urandom_range(0, n);
         lat_max = $urandom_range(0, 3);
         if (wr) fill_src(n);
         start_xfer(wr, a, 16'(n), mode, sn);
         wait_done(400);
         k = expect_k(mode, sn, n);
         check_xfer("rand", wr, a, n, k);
      end
      lat_max = 2;

      // Reset while a store is outstanding, with a start coincident with reset
      lat_min = 6;
      lat_max = 6;
      fill_src(3);
      start_xfer(1'b1, 32'h0000_4000, 16'd3, 0, 0);
      k = 0;
      while (wr_a_q.size() == 0 && k < 200) begin
         tick();
         k++;
      end
      chk("midrst store_issued", 32'(wr_a_q.size()), 32'd1);
      tick();
      rst_req = 1'b1;
      st_req = 1'b1; st_wr = 1'b0; st_a = 32'h0000_5000; st_n = 16'd5;
      tick();
      rst_req = 1'b0;
      src_q.delete();
      tick();
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst done_strobe", 32'(done_strobe), 32'd0);
      chk("midrst res_count", 32'(res_count), 32'd0);
      chk("midrst in_ready", 32'(bus.in_ready), 32'd0);
      chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst io_start", 32'(bus.io_start), 32'd0);
      chk("midrst io_write", 32'(bus.io_write), 32'd0);
      chk("midrst io_addr", bus.io_addr, 32'd0);
      chk("midrst io_data_write", 32'(bus.io_data_write), 32'd0);
      lat_min = 0;
      lat_max = 2;
      clear_obs();
      repeat (3) tick();
      chk("rst_start ignored", 32'(busy), 32'd0);
      inj_done = 1'b1;
      repeat (2) tick();
      chk("stray io_done busy", 32'(busy), 32'd0);
      chk("stray io_done done", 32'(done_cnt), 32'd0);
      chk("idle io_start", 32'(io_start_cnt), 32'd0);

      // Fresh single-byte transfer; a second start while busy must be ignored
      start_xfer(1'b0, 32'h0000_2000, 16'd1, 0, 0);
      st_req = 1'b1; st_wr = 1'b1; st_a = 32'h0000_3000; st_n = 16'd4;
      wait_done(200);
      check_xfer("after_rst", 1'b0, 32'h0000_2000, 1, 1);
      chk("after_rst reads", 32'(rd_a_q.size()), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
